// File: rtl/seq_div_pkg.sv
// Shared types and op decoding for the sequential RV32M divider.
package seq_div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_t;

    function automatic logic is_signed(input div_op_t op);
        return ~op[0];
    endfunction

    function automatic logic is_rem(input div_op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_special.sv
// Combinational detection of RISC-V divide-by-zero and signed-overflow cases
// and their architecturally mandated results.
module div_special
    import seq_div_pkg::*;
#(
    parameter int N = 32
) (
    input  div_op_t        op,
    input  logic [N-1:0]   dividend,
    input  logic [N-1:0]   divisor,
    output logic           special_valid,
    output logic [N-1:0]   special_result
);
    localparam logic [N-1:0] MIN = {1'b1, {(N-1){1'b0}}};

    logic div0, ovf;

    always_comb begin
        div0           = (divisor == '0);
        ovf            = is_signed(op) && (dividend == MIN) && (divisor == '1);
        special_valid  = div0 | ovf;
        special_result = '0;
        if (div0)
            special_result = is_rem(op) ? dividend : '1;
        else if (ovf)
            special_result = is_rem(op) ? '0 : MIN;
    end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider (DIV/DIVU/REM/REMU), N iterations plus a sign-fix cycle.
// Define SEQ_DIVIDER_EARLY_OUT_EN to let divide-by-zero/overflow skip the iterations.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(N) + 1;

    state_t        state, state_nxt;
    div_op_t       op_q;
    logic          qneg, rneg;
    logic [N-1:0]  a_q, b_q;
    logic [N-1:0]  rem, quo, dvs;
    logic [CW-1:0] cnt;

    logic [N:0]    shifted, diff;
    logic [N-1:0]  quo_fix, rem_fix, fix_res;

    div_op_t       sp_op;
    logic [N-1:0]  sp_a, sp_b, sp_res;
    logic          sp_valid, early;

    function automatic logic [N-1:0] mag(input logic [N-1:0] x, input logic sgn);
        return (sgn && x[N-1]) ? -x : x;
    endfunction

    // In IDLE the checker looks at the live request; afterwards at the latched one.
    assign sp_op = (state == IDLE) ? div_op_t'(op) : op_q;
    assign sp_a  = (state == IDLE) ? dividend : a_q;
    assign sp_b  = (state == IDLE) ? divisor  : b_q;

    div_special #(.N(N)) u_special (
        .op            (sp_op),
        .dividend      (sp_a),
        .divisor       (sp_b),
        .special_valid (sp_valid),
        .special_result(sp_res)
    );

`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    assign early = sp_valid;
`else
    assign early = 1'b0;
`endif

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = early ? FIX : RUN;
            RUN:  if (cnt == CW'(N-1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shifted = {rem, quo[N-1]};
        diff    = shifted - {1'b0, dvs};
        quo_fix = qneg ? -quo : quo;
        rem_fix = rneg ? -rem : rem;
        // Special cases always take the mandated value, whatever the iterations produced.
        if (sp_valid)          fix_res = sp_res;
        else if (is_rem(op_q)) fix_res = rem_fix;
        else                   fix_res = quo_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_DIV;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    op_q <= div_op_t'(op);
                    a_q  <= dividend;
                    b_q  <= divisor;
                    qneg <= is_signed(div_op_t'(op)) & (dividend[N-1] ^ divisor[N-1]);
                    rneg <= is_signed(div_op_t'(op)) & dividend[N-1];
                    quo  <= mag(dividend, is_signed(div_op_t'(op)));
                    dvs  <= mag(divisor, is_signed(div_op_t'(op)));
                    rem  <= '0;
                    cnt  <= '0;
                end
                RUN: begin
                    rem <= diff[N] ? shifted[N-1:0] : diff[N-1:0];
                    quo <= {quo[N-2:0], ~diff[N]};
                    cnt <= cnt + CW'(1);
                end
                FIX: result <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
    localparam int N = 32;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] dividend = '0, divisor = '0;
    logic         busy, done;
    logic [N-1:0] result;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    seq_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .result(result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Called #1 after the accepting edge; optionally pulses start mid-flight at cycle inj.
    task automatic wait_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int inj, input string tag, output logic [31:0] e);
        int cyc, bb, lat;
        bit got;
        e   = ref_div(o, a, b);
        lat = (EARLY && is_special(o, a, b)) ? 1 : N + 1;
        cyc = 0; bb = 0; got = 0;
        if (!busy) bb++;
        while (!got && cyc < 200) begin
            if (cyc == inj) begin
                start    = 1'b1;
                op       = ~o;
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (done) got = 1;
            else if (!busy) bb++;
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(lat));
        chk({tag, "_result"}, 64'(result), 64'(e));
        chk({tag, "_busy_low_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_busy_during"}, 64'(bb), 64'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input string tag);
        logic [31:0] e;
        op = o; dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(o, a, b, inj, tag, e);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(result), 64'(e));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e1, e2, a, b;
        logic [1:0]  o;
        int          dp;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'b01, 32'd100, 32'd7, -1, "divu_100_7");
        do_op(2'b11, 32'd100, 32'd7, -1, "remu_100_7");
        do_op(2'b00, -32'sd7, 32'd2, -1, "div_m7_2");
        do_op(2'b10, -32'sd7, 32'd2, -1, "rem_m7_2");
        do_op(2'b10, 32'd7, -32'sd2, -1, "rem_7_m2");
        do_op(2'b00, 32'd5, 32'd0, -1, "div_5_0");
        do_op(2'b11, 32'd5, 32'd0, -1, "remu_5_0");
        do_op(2'b00, -32'sd5, 32'd0, -1, "div_m5_0");
        do_op(2'b10, -32'sd5, 32'd0, -1, "rem_m5_0");
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, "rem_ovf");
        do_op(2'b01, 32'd1000, 32'd10, 5, "start_while_busy");

        // Start held through DONE is ignored there and accepted on the following edge.
        op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(2'b01, 32'd50, 32'd5, -1, "b2b_first", e1);
        op = 2'b00; dividend = -32'sd100; divisor = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_ignored_in_done", 64'(busy), 64'd0);
        chk("b2b_hold", 64'(result), 64'(e1));
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(2'b00, -32'sd100, 32'd7, -1, "b2b_second", e2);
        @(posedge clk); #1;
        chk("b2b_done_pulse", 64'(done), 64'd0);

        // Reset in the middle of the iterations.
        op = 2'b01; dividend = 32'd123456; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_result", 64'(result), 64'd0);
        dp = 0;
        repeat (2) begin @(posedge clk); #1; if (done) dp++; end
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (done || busy) dp++; end
        chk("midrst_no_done", 64'(dp), 64'd0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, -1, "post_rst_divu");

        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                4: b = -$urandom_range(1, 15);
                default: ;
            endcase
            do_op(o, a, b, -1, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
